// File: rtl/sr_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between N_CORES cores.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE, all outputs registered.
module sr_mem_arbiter #(
  parameter int         N_CORES   = 4,
  parameter logic [2:0] IDLE_CODE = 3'b000,
  parameter int         TIMEOUT   = 15,
  // Memory-instruction encodings shared with sr_cpu.vh
  parameter logic [2:0] AGU_LOAD  = 3'b010,
  parameter logic [2:0] AGU_STORE = 3'b011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*N_CORES-1:0]  core_instr,
  input  logic [32*N_CORES-1:0] core_addr,
  input  logic [32*N_CORES-1:0] core_wdata,
  output logic [N_CORES-1:0]    core_ack,
  output logic [31:0]           core_rdata,
  output logic [2:0]            mem_instr,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_data,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_sent,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         mem_instr_q, mem_instr_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic [N_CORES-1:0] core_ack_q, core_ack_d;
  logic [31:0]        core_rdata_q, core_rdata_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         rr_q, rr_d;
  logic               busy_q, busy_d;
  logic               tout_q, tout_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [7:0]         req;
  logic               found;
  logic [2:0]         pick;
  logic [2:0]         sel_instr;
  logic [31:0]        sel_addr, sel_wdata;
  logic [CW-1:0]      cnt_inc;
  logic [N_CORES-1:0] ack_onehot;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_CORES; i++) begin
      req[i] = (core_instr[3*i +: 3] == AGU_LOAD) || (core_instr[3*i +: 3] == AGU_STORE);
    end
  end

  // Search starts one past the last winner so a held request cannot starve others
  always_comb begin
    int       idx;
    logic [2:0] idx3;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx3  = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx  = (int'(rr_q) + k) % N_CORES;
      idx3 = 3'(idx);
      if (!found && req[idx3]) begin
        found = 1'b1;
        pick  = idx3;
      end
    end
  end

  always_comb begin
    sel_instr = IDLE_CODE;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (pick == 3'(i)) begin
        sel_instr = core_instr[3*i +: 3];
        sel_addr  = core_addr[32*i +: 32];
        sel_wdata = core_wdata[32*i +: 32];
      end
    end
  end

  assign cnt_inc    = cnt_q + CW'(1);
  assign ack_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    state_d      = state_q;
    mem_instr_d  = mem_instr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    core_ack_d   = core_ack_q;
    core_rdata_d = core_rdata_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    tout_d       = tout_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        core_ack_d  = '0;
        tout_d      = 1'b0;
        mem_instr_d = IDLE_CODE;
        if (found) begin
          mem_instr_d = sel_instr;
          mem_addr_d  = sel_addr;
          mem_data_d  = sel_wdata;
          grant_d     = pick;
          rr_d        = pick;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_instr_d = IDLE_CODE;
        if (mem_instr_q == AGU_STORE) begin
          core_ack_d = ack_onehot;
          state_d    = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_sent) begin
          core_rdata_d = mem_rdata;
          core_ack_d   = ack_onehot;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            core_rdata_d = 32'hFFFF_FFFF;
            core_ack_d   = ack_onehot;
            tout_d       = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      default: begin
        core_ack_d = '0;
        tout_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_instr_q  <= IDLE_CODE;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      core_ack_q   <= '0;
      core_rdata_q <= 32'hFFFF_FFFF;
      grant_q      <= '0;
      rr_q         <= 3'(N_CORES - 1);
      busy_q       <= 1'b0;
      tout_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mem_instr_q  <= mem_instr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      busy_q       <= busy_d;
      tout_q       <= tout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign core_ack    = core_ack_q;
  assign core_rdata  = core_rdata_q;
  assign mem_instr   = mem_instr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Bench for sr_mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order, latency and read data.
module tb_sr_mem_arbiter;

  localparam int         N      = 4;
  localparam int         TO     = 15;
  localparam logic [2:0] IDLE_C = 3'b000;
  localparam logic [2:0] LD     = 3'b010;
  localparam logic [2:0] ST     = 3'b011;

  logic            clk;
  logic            rst_n;
  logic [3*N-1:0]  core_instr;
  logic [32*N-1:0] core_addr;
  logic [32*N-1:0] core_wdata;
  logic [N-1:0]    core_ack;
  logic [31:0]     core_rdata;
  logic [2:0]      mem_instr;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_data;
  logic [31:0]     mem_rdata;
  logic            mem_sent;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  logic [2:0]  ci [N];
  logic [31:0] ca [N];
  logic [31:0] cw [N];

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int          rr_m    = N - 1;
  logic [31:0] rdata_m = 32'hFFFF_FFFF;

  sr_mem_arbiter #(.N_CORES(N), .IDLE_CODE(IDLE_C), .TIMEOUT(TO),
                   .AGU_LOAD(LD), .AGU_STORE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .core_instr(core_instr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdata(mem_rdata), .mem_sent(mem_sent), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    core_instr = '0;
    core_addr  = '0;
    core_wdata = '0;
    for (int i = 0; i < N; i++) begin
      core_instr[3*i +: 3]  = ci[i];
      core_addr[32*i +: 32] = ca[i];
      core_wdata[32*i +: 32] = cw[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) begin
      ci[i] = IDLE_C;
      ca[i] = $urandom;
      cw[i] = $urandom;
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      ci[i] = 3'($urandom_range(0, 7));
      ca[i] = $urandom;
      cw[i] = $urandom;
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (ci[idx] == LD || ci[idx] == ST) return idx;
    end
    return -1;
  endfunction

  // Runs one arbitration starting from an idle DUT with core inputs already set.
  // lat: wait cycle (1-based) in which mem_sent arrives; > TO means never.
  task automatic do_txn(input int lat, input logic [31:0] rval, input bit spur,
                        input bit scr, output int g);
    logic [2:0]  e_instr;
    logic [31:0] e_addr, e_data;
    logic [N-1:0] e_ack;
    g = model_pick();
    mem_sent  = spur;
    mem_rdata = $urandom;
    if (g < 0) begin
      step();
      mem_sent = 1'b0;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_instr", 32'(mem_instr), 32'(IDLE_C));
      chk("idle_ack", 32'(core_ack), 0);
      return;
    end
    e_instr = ci[g];
    e_addr  = ca[g];
    e_data  = cw[g];
    e_ack   = N'(1) << g;
    step();
    rr_m = g;
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("issue_busy", 32'(busy), 1);
    chk("issue_instr", 32'(mem_instr), 32'(e_instr));
    chk("issue_addr", mem_addr, e_addr);
    chk("issue_data", mem_data, e_data);
    chk("issue_ack", 32'(core_ack), 0);
    if (scr) scramble();
    mem_sent  = spur;
    mem_rdata = $urandom;
    step();
    mem_sent = 1'b0;
    chk("post_issue_instr", 32'(mem_instr), 32'(IDLE_C));
    if (e_instr == ST) begin
      chk("store_ack", 32'(core_ack), 32'(e_ack));
      chk("store_rdata_hold", core_rdata, rdata_m);
      chk("store_tout", 32'(timeout_err), 0);
    end else begin
      chk("load_issue_ack", 32'(core_ack), 0);
      for (int w = 1; w <= TO; w++) begin
        mem_sent  = (w == lat);
        mem_rdata = (w == lat) ? rval : $urandom;
        step();
        mem_sent = 1'b0;
        if (w == lat) begin
          rdata_m = rval;
          chk("load_ack", 32'(core_ack), 32'(e_ack));
          chk("load_rdata", core_rdata, rdata_m);
          chk("load_tout", 32'(timeout_err), 0);
          break;
        end else if (w == TO) begin
          rdata_m = 32'hFFFF_FFFF;
          chk("tout_ack", 32'(core_ack), 32'(e_ack));
          chk("tout_rdata", core_rdata, rdata_m);
          chk("tout_err", 32'(timeout_err), 1);
        end else begin
          chk("wait_ack", 32'(core_ack), 0);
        end
      end
    end
    chk("done_busy", 32'(busy), 1);
    mem_sent  = spur;
    mem_rdata = $urandom;
    step();
    mem_sent = 1'b0;
    chk("done_ack", 32'(core_ack), 0);
    chk("done_tout", 32'(timeout_err), 0);
    chk("done_busy_clr", 32'(busy), 0);
    chk("done_addr_hold", mem_addr, e_addr);
    chk("done_rdata_hold", core_rdata, rdata_m);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, 32'(mem_instr), 32'(IDLE_C));
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_ack"}, 32'(core_ack), 0);
    chk({tag, "_rdata"}, core_rdata, 32'hFFFF_FFFF);
    chk({tag, "_gid"}, 32'(grant_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int g;
    int seq [5];
    rst_n = 1'b0;
    mem_sent = 1'b0;
    mem_rdata = '0;
    all_idle();
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // core 2 store
    all_idle();
    ci[2] = ST; ca[2] = 32'd5; cw[2] = 32'hDEAD_BEEF;
    do_txn(1, 0, 0, 1, g);
    chk("store_gid", 32'(g), 2);

    // core 1 load, data on the first wait cycle
    all_idle();
    ci[1] = LD; ca[1] = 32'd5;
    do_txn(1, 32'hDEAD_BEEF, 0, 1, g);
    chk("load_gid", 32'(g), 1);

    // timeout
    all_idle();
    ci[0] = LD;
    do_txn(TO + 1, 0, 0, 1, g);

    // spurious mem_sent and an unused code on core 0
    all_idle();
    ci[0] = 3'b101;
    for (int i = 0; i < 3; i++) do_txn(1, 0, 1, 0, g);

    // reset in the middle of a WAIT
    all_idle();
    ci[0] = LD;
    step(); step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    chk("midrst_ack_hold", 32'(core_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = N - 1;
    rdata_m = 32'hFFFF_FFFF;
    all_idle();
    ci[3] = LD;
    do_txn(2, 32'h1234_5678, 0, 1, g);
    chk("post_rst_gid", 32'(g), 3);

    // all cores hold loads continuously from a fresh reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    rr_m = N - 1;
    rdata_m = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) begin ci[i] = LD; ca[i] = 32'(i); end
    for (int t = 0; t < 5; t++) begin
      do_txn(1 + (t % 3), $urandom, 0, 0, g);
      seq[t] = g;
    end
    chk("rr_seq0", 32'(seq[0]), 0);
    chk("rr_seq1", 32'(seq[1]), 1);
    chk("rr_seq2", 32'(seq[2]), 2);
    chk("rr_seq3", 32'(seq[3]), 3);
    chk("rr_seq4", 32'(seq[4]), 0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: ci[i] = LD;
          1: ci[i] = ST;
          2: ci[i] = IDLE_C;
          default: ci[i] = 3'($urandom_range(4, 7));
        endcase
        ca[i] = $urandom;
        cw[i] = $urandom;
      end
      do_txn($urandom_range(1, TO + 1), $urandom, 1'($urandom_range(0, 1)), 1, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_mem_arbiter.md
SR_MEM_ARBITER -- requirements
Module: sr_mem_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter IDLE_CODE, default 3'b000, memory-instruction code driven when no access is issued; SHALL differ from AGU_LOAD and AGU_STORE (sr_cpu.vh).
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles waiting for load data.
REQ-004 clk  input  1  clock, rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 core_instr  input  3*N_CORES  per-core memory instruction; slice i = core i.
REQ-007 core_addr  input  32*N_CORES  per-core word address.
REQ-008 core_wdata  input  32*N_CORES  per-core store data.
REQ-009 core_ack  output  N_CORES  one-cycle completion pulse, one-hot.
REQ-010 core_rdata  output  32  load data, shared by all cores, valid while core_ack is asserted.
REQ-011 mem_instr  output  3  instruction to the memory controller.
REQ-012 mem_addr  output  32  address to the memory controller.
REQ-013 mem_data  output  32  store data to the memory controller.
REQ-014 mem_rdata  input  32  load data from the memory controller.
REQ-015 mem_sent  input  1  load-data-valid strobe from the memory controller.
REQ-016 grant_id  output  3  index of the core currently or last granted.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_err  output  1  one-cycle pulse on a load timeout.

Function
REQ-019 Core i requests SHALL be active when its core_instr slice equals AGU_LOAD or AGU_STORE; any other code SHALL be treated as no request.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE, all outputs registered.
REQ-021 IDLE, any request active: grant the first active core searching round-robin from rr_ptr+1 with wrap-around; latch its instr/addr/wdata onto mem_*; grant_id <= g, rr_ptr <= g; go to ISSUE.
REQ-022 IDLE, no request: mem_instr SHALL stay IDLE_CODE, state unchanged.
REQ-023 ISSUE: mem_instr SHALL be non-idle for exactly this one cycle, then IDLE_CODE; mem_addr/mem_data SHALL hold until the next grant.
REQ-024 ISSUE with a store: core_ack[g] <= 1, go to DONE; store ack is visible 2 cycles after the grant cycle.
REQ-025 ISSUE with a load: clear the wait counter, go to WAIT.
REQ-026 WAIT with mem_sent=1: core_rdata <= mem_rdata, core_ack[g] <= 1, go to DONE; nominal load ack is 3 cycles after the grant cycle.
REQ-027 WAIT without mem_sent: increment the counter; when it reaches TIMEOUT: core_rdata <= 32'hFFFFFFFF, core_ack[g] <= 1, timeout_err <= 1, go to DONE.
REQ-028 DONE: core_ack and timeout_err SHALL clear; no arbitration occurs; go to IDLE. This guarantees an acknowledged core has one cycle to drop or change its request before re-sampling.
REQ-029 mem_sent outside WAIT SHALL be ignored.
REQ-030 Core inputs SHALL be sampled only in IDLE; changes while granted SHALL NOT affect the transaction in flight.
REQ-031 At most one core_ack bit SHALL be high in any cycle.
REQ-032 core_rdata SHALL hold its value between acks; store acks SHALL NOT modify it.

Reset
REQ-033 On rst_n low, immediately: state IDLE, mem_instr IDLE_CODE, mem_addr 0, mem_data 0, core_ack 0, core_rdata 32'hFFFFFFFF, grant_id 0, busy 0, timeout_err 0, rr_ptr N_CORES-1, wait counter 0.
REQ-034 Reset mid-transaction SHALL abandon it with no ack; the first grant after reset SHALL search from core 0.

Verification
REQ-035 Core 2 stores 0xDEADBEEF at address 5, others idle -> mem_instr=AGU_STORE for one cycle at T+1 with addr 5, core_ack=4'b0100 at T+2, then busy=0.
REQ-036 Core 1 loads address 5 with the controller model returning 0xDEADBEEF -> mem_sent at T+2, core_ack=4'b0010 and core_rdata=0xDEADBEEF at T+3.
REQ-037 All 4 cores hold loads continuously -> grants in order 0,1,2,3,0; no core is granted twice in a row; one ack per transaction.
REQ-038 Load with mem_sent held low -> core_ack and timeout_err pulse together after TIMEOUT wait cycles; core_rdata=0xFFFFFFFF.
REQ-039 rst_n asserted during WAIT -> all outputs at REQ-033 values at once, no ack; after release, a core-3 request is granted normally.
REQ-040 Spurious mem_sent in IDLE and DONE, and an unused instruction code on core 0 -> no ack, no grant, mem_instr stays IDLE_CODE.
